// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-bus request/response bundle between the LSU and memory
interface lsu_if;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one bus access per start, lane alignment and load extension
// Optional: LSU_MISALIGN_CHECK_EN completes misaligned accesses locally with a misalign flag.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  msize,
  input  logic        munsigned,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  lsu_if.master       dbus,
  output logic        lsu_busy,
  output logic        lsu_data_ok,
  output logic [63:0] rdata,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        write_q, write_d;
  logic [63:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic        start_misaligned;
  logic [7:0]  strobe_base;
  logic [63:0] shifted;
  logic [63:0] load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (msize)
      2'd0:    start_misaligned = 1'b0;
      2'd1:    start_misaligned = addr[0];
      2'd2:    start_misaligned = |addr[1:0];
      default: start_misaligned = |addr[2:0];
    endcase
  end
`else
  assign start_misaligned = 1'b0;
`endif

  always_comb begin
    case (size_q)
      2'd0:    strobe_base = 8'h01;
      2'd1:    strobe_base = 8'h03;
      2'd2:    strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
  end

  // Bring the addressed lane down to bit 0 before sizing and extending.
  assign shifted = dbus.dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if ((mem_read || mem_write) && !start_misaligned) begin
            addr_d     = addr;
            wdata_d    = wdata;
            size_d     = msize;
            unsigned_d = munsigned;
            write_d    = mem_write;
            state_d    = REQ;
          end else begin
            misalign_d = start_misaligned && (mem_read || mem_write);
            state_d    = DONE;
          end
        end
      end
      REQ: begin
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            state_d = DONE;
            if (!write_q) rdata_d = load_ext;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus.dresp_data_ok) begin
          state_d = DONE;
          if (!write_q) rdata_d = load_ext;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ);
    busy_d  = (state_d == REQ) || (state_d == WAIT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign dbus.dreq_valid  = valid_q;
  assign dbus.dreq_write  = write_q;
  assign dbus.dreq_addr   = addr_q;
  assign dbus.dreq_size   = size_q;
  assign dbus.dreq_strobe = strobe_base << addr_q[2:0];
  assign dbus.dreq_data   = wdata_q << {addr_q[2:0], 3'b000};

  assign lsu_busy    = busy_q;
  assign lsu_data_ok = done_q;
  assign rdata       = rdata_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_read, mem_write, munsigned;
  logic [1:0]  msize;
  logic [63:0] addr, wdata;
  logic        lsu_busy, lsu_data_ok, misalign;
  logic [63:0] rdata;

  lsu_if bus ();

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .msize(msize), .munsigned(munsigned), .addr(addr), .wdata(wdata), .dbus(bus),
    .lsu_busy(lsu_busy), .lsu_data_ok(lsu_data_ok), .rdata(rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] d);
    start = 1'b1; mem_read = rd; mem_write = wr; msize = sz; munsigned = uns; addr = a; wdata = d;
    tick;
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; msize = 2'd0;
    munsigned = 1'b0; addr = '0; wdata = '0;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
    #2;
    check_eq("rst_valid", bus.dreq_valid, 0);
    check_eq("rst_busy", lsu_busy, 0);
    check_eq("rst_data_ok", lsu_data_ok, 0);
    check_eq("rst_misalign", misalign, 0);
    check_eq("rst_rdata", rdata, 0);
    tick; rst = 1'b0; tick;

    // signed byte load through WAIT
    issue(1, 0, 2'd0, 0, 64'h1003, 0);
    check_eq("lb_valid", bus.dreq_valid, 1);
    check_eq("lb_write", bus.dreq_write, 0);
    check_eq("lb_addr", bus.dreq_addr, 64'h1003);
    check_eq("lb_size", bus.dreq_size, 0);
    check_eq("lb_strobe", bus.dreq_strobe, 8'h08);
    check_eq("lb_busy", lsu_busy, 1);
    bus.dresp_addr_ok = 1'b1; tick; bus.dresp_addr_ok = 1'b0;
    check_eq("lb_wait_valid", bus.dreq_valid, 0);
    check_eq("lb_wait_busy", lsu_busy, 1);
    bus.dresp_data = 64'h00000000_80000000; bus.dresp_data_ok = 1'b1; tick; bus.dresp_data_ok = 1'b0;
    check_eq("lb_done", lsu_data_ok, 1);
    check_eq("lb_done_busy", lsu_busy, 0);
    check_eq("lb_rdata", rdata, 64'hFFFFFFFF_FFFFFF80);
    tick;
    check_eq("lb_pulse_end", lsu_data_ok, 0);
    check_eq("lb_rdata_hold", rdata, 64'hFFFFFFFF_FFFFFF80);

    // half store
    issue(0, 1, 2'd1, 0, 64'h2006, 64'hABCD);
    check_eq("sh_write", bus.dreq_write, 1);
    check_eq("sh_strobe", bus.dreq_strobe, 8'hC0);
    check_eq("sh_data", bus.dreq_data, 64'hABCD0000_00000000);
    bus.dresp_addr_ok = 1'b1; tick; bus.dresp_addr_ok = 1'b0;
    check_eq("sh_wait_done", lsu_data_ok, 0);
    bus.dresp_data = 64'hDEADBEEF_DEADBEEF; bus.dresp_data_ok = 1'b1; tick; bus.dresp_data_ok = 1'b0;
    check_eq("sh_done", lsu_data_ok, 1);
    check_eq("sh_rdata_keep", rdata, 64'hFFFFFFFF_FFFFFF80);
    tick;

    // unsigned word load, addr_ok stalled 3 cycles with an ignored start
    issue(1, 0, 2'd2, 1, 64'h3004, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lw_stall_valid", bus.dreq_valid, 1);
      check_eq("lw_stall_addr", bus.dreq_addr, 64'h3004);
      check_eq("lw_stall_strobe", bus.dreq_strobe, 8'hF0);
      if (i == 1) begin
        start = 1'b1; mem_write = 1'b1; addr = 64'h5000;
      end
      tick;
      start = 1'b0; mem_write = 1'b0;
    end
    check_eq("lw_after_stall_addr", bus.dreq_addr, 64'h3004);
    bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'h89ABCDEF_00000000;
    tick;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    check_eq("lw_done", lsu_data_ok, 1);
    check_eq("lw_rdata", rdata, 64'h00000000_89ABCDEF);
    tick;

    // non-memory start, then a new load accepted in DONE
    start = 1'b1; mem_read = 1'b0; mem_write = 1'b0; tick; start = 1'b0;
    check_eq("nop_valid", bus.dreq_valid, 0);
    check_eq("nop_done", lsu_data_ok, 1);
    check_eq("nop_rdata", rdata, 64'h00000000_89ABCDEF);
    issue(1, 0, 2'd3, 0, 64'h4000, 0);
    check_eq("ld_valid", bus.dreq_valid, 1);
    check_eq("ld_strobe", bus.dreq_strobe, 8'hFF);
    bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'h80000000_00000001;
    tick;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    check_eq("ld_rdata", rdata, 64'h80000000_00000001);
    tick;

    // signed half load
    issue(1, 0, 2'd1, 0, 64'h6002, 0);
    check_eq("lh_strobe", bus.dreq_strobe, 8'h0C);
    bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'h00000000_F2340000;
    tick;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    check_eq("lh_rdata", rdata, 64'hFFFFFFFF_FFFFF234);
    tick;

    // reset while waiting for data
    issue(1, 0, 2'd2, 0, 64'h7000, 0);
    bus.dresp_addr_ok = 1'b1; tick; bus.dresp_addr_ok = 1'b0;
    check_eq("rw_busy", lsu_busy, 1);
    rst = 1'b1; #1;
    check_eq("rw_valid", bus.dreq_valid, 0);
    check_eq("rw_busy0", lsu_busy, 0);
    check_eq("rw_data_ok", lsu_data_ok, 0);
    check_eq("rw_rdata", rdata, 0);
    check_eq("rw_addr", bus.dreq_addr, 0);
    check_eq("rw_data", bus.dreq_data, 0);
    tick; rst = 1'b0;
    bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'h12345678_12345678; tick; bus.dresp_data_ok = 1'b0;
    check_eq("rw_late_data_ok", lsu_data_ok, 0);
    tick;
    check_eq("rw_late_data_ok2", lsu_data_ok, 0);
    check_eq("rw_late_rdata", rdata, 0);

    // misaligned word load
    issue(1, 0, 2'd2, 0, 64'h1002, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check_eq("mis_valid", bus.dreq_valid, 0);
    check_eq("mis_flag", misalign, 1);
    check_eq("mis_done", lsu_data_ok, 1);
    check_eq("mis_rdata", rdata, 0);
    tick;
    check_eq("mis_flag_end", misalign, 0);
`else
    check_eq("mis_valid", bus.dreq_valid, 1);
    check_eq("mis_strobe", bus.dreq_strobe, 8'h3C);
    bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'h00001234_56780000;
    tick;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
    check_eq("mis_done", lsu_data_ok, 1);
    check_eq("mis_flag", misalign, 0);
    check_eq("mis_rdata", rdata, 64'h00000000_12345678);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  system clock; all state rising-edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  one-cycle pulse from execute stage when its result is ready (execute data_ok).
REQ-004 mem_read  input  1  instruction is a load.
REQ-005 mem_write  input  1  instruction is a store (mem_read and mem_write never both 1).
REQ-006 msize  input  2  0=byte, 1=half, 2=word, 3=double.
REQ-007 munsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 addr  input  64  effective address (execute ALU result).
REQ-009 wdata  input  64  store data, right-aligned.
REQ-010 dreq_valid  output  1  bus request valid.
REQ-011 dreq_write  output  1  bus request is a store.
REQ-012 dreq_addr  output  64  bus address.
REQ-013 dreq_size  output  2  copy of msize.
REQ-014 dreq_strobe  output  8  byte enables.
REQ-015 dreq_data  output  64  lane-aligned store data.
REQ-016 dresp_addr_ok  input  1  bus accepted request this cycle.
REQ-017 dresp_data_ok  input  1  bus completed access this cycle.
REQ-018 dresp_data  input  64  raw 64-bit load data, valid with dresp_data_ok.
REQ-019 lsu_busy  output  1  high from cycle after start until completion.
REQ-020 lsu_data_ok  output  1  one-cycle completion pulse.
REQ-021 rdata  output  64  extended load result; held until next completion.
REQ-022 misalign  output  1  misaligned-access flag, pulsed with lsu_data_ok (configured builds only).

Function
REQ-023 FSM states IDLE, REQ, WAIT, DONE; registered outputs.
REQ-024 IDLE + start with mem_read|mem_write: capture addr/wdata/msize/munsigned/op, go REQ; start without either: go DONE, no bus request.
REQ-025 REQ: dreq_valid=1, request fields stable; dresp_addr_ok=0 -> stay; addr_ok=1 and data_ok=0 -> WAIT; addr_ok=1 and data_ok=1 same cycle -> DONE.
REQ-026 WAIT: dreq_valid=0; dresp_data_ok -> capture data, go DONE.
REQ-027 DONE: lsu_data_ok=1 for exactly one cycle, lsu_busy=0, return IDLE; start in DONE is accepted.
REQ-028 start while REQ/WAIT is ignored.
REQ-029 Strobe = {0x01,0x03,0x0F,0xFF}[msize] << addr[2:0], truncated to 8 bits.
REQ-030 dreq_data = wdata << (8*addr[2:0]), truncated to 64 bits.
REQ-031 Load: shift dresp_data right by 8*addr[2:0], keep 8/16/32/64 bits, extend per munsigned.
REQ-032 rdata updates only on load completion; stores and non-memory ops leave it unchanged.

Reset
REQ-033 rst forces IDLE, dreq_valid=0, lsu_busy=0, lsu_data_ok=0, misalign=0, rdata=0, all captured fields 0, including mid-transaction; no completion pulse follows.

Configuration
REQ-034 Macro LSU_MISALIGN_CHECK_EN defined: start with addr not a multiple of size goes to DONE, no bus request, misalign=1 with lsu_data_ok, rdata unchanged.
REQ-035 Macro undefined: no check; misalign tied 0; access issued per REQ-029/030.

Verification
REQ-036 Load byte signed, addr=0x1003, dresp_data=0x00000000_80000000 -> strobe 0x08, rdata=0xFFFFFFFF_FFFFFF80.
REQ-037 Store half, addr=0x2006, wdata=0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD0000_00000000, lsu_data_ok one cycle after data_ok.
REQ-038 addr_ok held low 3 cycles -> dreq_valid and fields stable 3 cycles; addr_ok+data_ok same cycle -> lsu_data_ok next cycle.
REQ-039 start with mem_read=mem_write=0 -> no dreq_valid, lsu_data_ok on cycle after start.
REQ-040 rst asserted in WAIT -> outputs zero immediately; later data_ok ignored, no lsu_data_ok.
REQ-041 With LSU_MISALIGN_CHECK_EN, word load addr=0x1002 -> no dreq_valid, misalign=1 and lsu_data_ok together.
